// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file.
// Selects the commit value, writes on posedge, bypasses to both read ports.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            control_wb_in,
    input  logic [DATA_WIDTH-1:0] read_data_in,
    input  logic [DATA_WIDTH-1:0] ALU_result_in,
    input  logic [31:0]           reg_dst_address_in,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    output logic                  wb_en_out,
    output logic [ADDR_WIDTH-1:0] wb_addr_out,
    output logic [31:0]           retire_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [31:0]           r_retire_count;

    logic                  w_reg_write;
    logic                  w_mem_to_reg;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_wb_en;
    logic                  w_unused_dst;

    assign w_reg_write  = control_wb_in[1];
    assign w_mem_to_reg = control_wb_in[0];
    assign w_wb_addr    = reg_dst_address_in[ADDR_WIDTH-1:0];
    assign w_unused_dst = ^reg_dst_address_in[31:ADDR_WIDTH];

    // Select the write-back value and qualify the enable against $0.
    always_comb begin
        w_wb_data = w_mem_to_reg ? read_data_in : ALU_result_in;
        w_wb_en   = w_reg_write && (w_wb_addr != '0);
    end

    // Commit the selected value and count it; reset clears everything.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_retire_count <= '0;
        end else if (w_wb_en) begin
            r_regs[w_wb_addr] <= w_wb_data;
            r_retire_count    <= r_retire_count + 32'd1;
        end
    end

    // Read ports: $0 reads zero, a same-cycle write is bypassed.
    always_comb begin
        read_data1 = r_regs[read_reg1];
        read_data2 = r_regs[read_reg2];
        if (read_reg1 == '0) begin
            read_data1 = '0;
        end else if (w_wb_en && (read_reg1 == w_wb_addr)) begin
            read_data1 = w_wb_data;
        end
        if (read_reg2 == '0) begin
            read_data2 = '0;
        end else if (w_wb_en && (read_reg2 == w_wb_addr)) begin
            read_data2 = w_wb_data;
        end
    end

    assign wb_data_out  = w_wb_data;
    assign wb_en_out    = w_wb_en;
    assign wb_addr_out  = w_wb_addr;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// Random and directed writes compared against an array-based model.
module tb_wb_regfile;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  control_wb_in;
    logic [31:0] read_data_in;
    logic [31:0] ALU_result_in;
    logic [31:0] reg_dst_address_in;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] wb_data_out;
    logic        wb_en_out;
    logic [4:0]  wb_addr_out;
    logic [31:0] retire_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    wb_regfile dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .control_wb_in      (control_wb_in),
        .read_data_in       (read_data_in),
        .ALU_result_in      (ALU_result_in),
        .reg_dst_address_in (reg_dst_address_in),
        .read_reg1          (read_reg1),
        .read_reg2          (read_reg2),
        .read_data1         (read_data1),
        .read_data2         (read_data2),
        .wb_data_out        (wb_data_out),
        .wb_en_out          (wb_en_out),
        .wb_addr_out        (wb_addr_out),
        .retire_count       (retire_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_count = 32'h0;
    endfunction

    function automatic logic m_en();
        return control_wb_in[1] && (reg_dst_address_in[4:0] != 5'd0);
    endfunction

    function automatic logic [31:0] m_data();
        return control_wb_in[0] ? read_data_in : ALU_result_in;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (m_en() && idx == reg_dst_address_in[4:0]) return m_data();
        return m_regs[idx];
    endfunction

    function automatic void m_commit();
        if (m_en()) begin
            m_regs[reg_dst_address_in[4:0]] = m_data();
            m_count = m_count + 32'd1;
        end
    endfunction

    // Drive a MEM/WB bundle on the negedge, like the upstream register.
    task automatic drive(input logic [1:0] c, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [31:0] dst,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge CLK);
        control_wb_in      = c;
        read_data_in       = rd;
        ALU_result_in      = alu;
        reg_dst_address_in = dst;
        read_reg1          = r1;
        read_reg2          = r2;
        #2;
    endtask

    // Let the posedge happen, then update the model.
    task automatic clock_commit();
        @(posedge CLK);
        if (RST_N) m_commit();
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        control_wb_in = 2'b10;
        read_data_in = 32'h0;
        ALU_result_in = 32'h5555_AAAA;
        reg_dst_address_in = 32'd3;
        read_reg1 = 5'd3;
        read_reg2 = 5'd31;
        model_reset();
        @(posedge CLK);
        #1;
        total++;
        if (retire_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_count got=%h exp=0", retire_count);
        end
        control_wb_in = 2'b00;
        #1;
        total++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_reads got=%h/%h exp=0", read_data1, read_data2);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        drive(2'b10, 32'h0, 32'h1234_5678, 32'd5, 5'd5, 5'd0);
        clock_commit();
        total++;
        if (read_data1 !== 32'h1234_5678 || retire_count !== 32'd1) begin
            bad++;
            $display("FAIL basic_alu got=%h cnt=%0d exp=12345678 cnt=1",
                     read_data1, retire_count);
        end
        drive(2'b11, 32'hDEAD_BEEF, 32'h1111_1111, 32'd6, 5'd0, 5'd6);
        total++;
        if (wb_data_out !== 32'hDEAD_BEEF || wb_en_out !== 1'b1
            || wb_addr_out !== 5'd6) begin
            bad++;
            $display("FAIL basic_wbout got=%h en=%b a=%0d exp=deadbeef 1 6",
                     wb_data_out, wb_en_out, wb_addr_out);
        end
        clock_commit();
        control_wb_in = 2'b00;
        #1;
        total++;
        if (read_data2 !== 32'hDEAD_BEEF || retire_count !== 32'd2) begin
            bad++;
            $display("FAIL basic_mem got=%h cnt=%0d exp=deadbeef cnt=2",
                     read_data2, retire_count);
        end
    endtask

    task automatic test_bypass();
        drive(2'b10, 32'h0, 32'hCAFE_F00D, 32'd9, 5'd9, 5'd9);
        total++;
        if (read_data1 !== 32'hCAFE_F00D || read_data2 !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL bypass got=%h/%h exp=cafef00d", read_data1, read_data2);
        end
        total++;
        if (dut.r_regs[9] === 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL bypass_early got=%h exp=not yet written", dut.r_regs[9]);
        end
        clock_commit();
    endtask

    task automatic test_zero();
        logic [31:0] c0;
        c0 = m_count;
        drive(2'b10, 32'h0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
        total++;
        if (wb_en_out !== 1'b0 || read_data1 !== 32'h0) begin
            bad++;
            $display("FAIL zero_dst en=%b rd=%h exp=0 0", wb_en_out, read_data1);
        end
        clock_commit();
        drive(2'b10, 32'h0, 32'hFFFF_FFFF, 32'h0000_0020, 5'd0, 5'd1);
        total++;
        if (wb_en_out !== 1'b0 || wb_addr_out !== 5'd0) begin
            bad++;
            $display("FAIL zero_upper en=%b a=%0d exp=0 0", wb_en_out, wb_addr_out);
        end
        clock_commit();
        total++;
        if (retire_count !== c0 || read_data2 !== m_regs[1]) begin
            bad++;
            $display("FAIL zero_count cnt=%0d r1=%h exp=%0d %h",
                     retire_count, read_data2, c0, m_regs[1]);
        end
    endtask

    task automatic test_nowrite();
        logic [31:0] c0;
        c0 = m_count;
        drive(2'b01, 32'hxxxx_xxxx, 32'h7777_7777, 32'd7, 5'd7, 5'd7);
        total++;
        if (wb_en_out !== 1'b0 || read_data1 !== m_regs[7]) begin
            bad++;
            $display("FAIL nowrite_comb en=%b rd=%h exp=0 %h",
                     wb_en_out, read_data1, m_regs[7]);
        end
        clock_commit();
        total++;
        if (read_data1 !== m_regs[7] || retire_count !== c0) begin
            bad++;
            $display("FAIL nowrite_after rd=%h cnt=%0d exp=%h %0d",
                     read_data1, retire_count, m_regs[7], c0);
        end
    endtask

    task automatic test_back_to_back();
        drive(2'b10, 32'h0, 32'hAAAA_0001, 32'd12, 5'd12, 5'd0);
        clock_commit();
        drive(2'b11, 32'hBBBB_0002, 32'h0, 32'd12, 5'd12, 5'd0);
        clock_commit();
        control_wb_in = 2'b00;
        #1;
        total++;
        if (read_data1 !== 32'hBBBB_0002 || retire_count !== m_count) begin
            bad++;
            $display("FAIL b2b rd=%h cnt=%0d exp=bbbb0002 %0d",
                     read_data1, retire_count, m_count);
        end
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [31:0] dst;
        logic [4:0]  r1;
        logic [4:0]  r2;
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            c   = 2'($urandom_range(0, 3));
            dst = $urandom;
            if ($urandom_range(0, 7) == 0) dst[4:0] = 5'd0;
            r1  = 5'($urandom);
            r2  = ($urandom_range(0, 2) == 0) ? dst[4:0] : 5'($urandom);
            drive(c, $urandom, $urandom, dst, r1, r2);
            total++;
            if (wb_en_out !== m_en() || wb_addr_out !== dst[4:0]
                || wb_data_out !== m_data()) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_wb i=%0d en=%b a=%0d d=%h exp=%b %0d %h",
                             i, wb_en_out, wb_addr_out, wb_data_out,
                             m_en(), dst[4:0], m_data());
            end
            total++;
            if (read_data1 !== m_read(r1) || read_data2 !== m_read(r2)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_rd i=%0d got=%h/%h exp=%h/%h",
                             i, read_data1, read_data2, m_read(r1), m_read(r2));
            end
            clock_commit();
            total++;
            if (retire_count !== m_count) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_cnt i=%0d got=%0d exp=%0d",
                             i, retire_count, m_count);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(2'b10, 32'h0, 32'h0BAD_F00D, 32'd20, 5'd20, 5'd5);
        clock_commit();
        drive(2'b00, 32'h0, 32'h0, 32'd0, 5'd20, 5'd5);
        RST_N = 1'b0;
        model_reset();
        #1;
        total++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0
            || retire_count !== 32'h0) begin
            bad++;
            $display("FAIL async_reset rd=%h/%h cnt=%0d exp=0",
                     read_data1, read_data2, retire_count);
        end
        drive(2'b10, 32'h0, 32'h1357_9BDF, 32'd20, 5'd20, 5'd0);
        clock_commit();
        control_wb_in = 2'b00;
        #1;
        total++;
        if (read_data1 !== 32'h0 || retire_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_blocks rd=%h cnt=%0d exp=0 0",
                     read_data1, retire_count);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        drive(2'b10, 32'h0, 32'h2468_ACE0, 32'd20, 5'd0, 5'd0);
        clock_commit();
        control_wb_in = 2'b00;
        read_reg1 = 5'd20;
        #1;
        total++;
        if (read_data1 !== 32'h2468_ACE0 || retire_count !== 32'd1) begin
            bad++;
            $display("FAIL release_write rd=%h cnt=%0d exp=2468ace0 1",
                     read_data1, retire_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge CLK);
        control_wb_in = 2'b00;
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m_count = 32'hFFFF_FFFF;
        drive(2'b10, 32'h0, 32'h0000_0042, 32'd31, 5'd31, 5'd0);
        clock_commit();
        total++;
        if (retire_count !== 32'h0 || retire_count !== m_count) begin
            bad++;
            $display("FAIL wrap cnt=%h exp=0", retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_nowrite();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the outputs of the MEM/WB pipeline register and selects the write-back value (memory read data or ALU result). It commits that value into a 32 x 32-bit register file on the rising clock edge. It serves the decode stage through two read ports with same-cycle write-through bypass, and keeps a retired-write counter for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, register and datapath width
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH

Ports:
- CLK  input  1  clock; all state updates on posedge
- RST_N  input  1  asynchronous, active-low reset
- control_wb_in  input  2  bit1 = RegWrite, bit0 = MemtoReg (from MEM/WB register)
- read_data_in  input  32  data-memory read value
- ALU_result_in  input  32  ALU result
- reg_dst_address_in  input  32  destination register; only bits [ADDR_WIDTH-1:0] used, upper bits ignored
- read_reg1, read_reg2  input  ADDR_WIDTH  decode-stage read indices
- read_data1, read_data2  output  32  read-port values (combinational)
- wb_data_out  output  32  selected write-back value (combinational, for forwarding unit)
- wb_en_out  output  1  effective write enable (combinational)
- wb_addr_out  output  ADDR_WIDTH  effective destination index (combinational)
- retire_count  output  32  number of committed register writes (registered)

## Operation
- wb_data = MemtoReg ? read_data_in : ALU_result_in.
- wb_en = RegWrite AND (dst index != 0); wb_addr = reg_dst_address_in[ADDR_WIDTH-1:0].
- Register $0 is hardwired to zero. Writes to $0 are dropped, are not counted, and never assert wb_en_out.
- Commit: on posedge CLK with wb_en=1, regs[wb_addr] <= wb_data and retire_count <= retire_count + 1.
- Read port n: if read_regn == 0, output 0. Else if wb_en and read_regn == wb_addr, output wb_data (bypass). Else output regs[read_regn].
- Both ports are independent. Identical indices on both ports, each equal to wb_addr, both return the bypassed value.
- retire_count is 32-bit and wraps 0xFFFFFFFF -> 0 with no flag.
- MemtoReg is ignored when RegWrite=0. X on read_data_in must not propagate into the registers when RegWrite=0.

## Timing
- Reset (RST_N low, asynchronous): all registers = 0 and retire_count = 0 immediately, without a clock edge. While RST_N is low, writes are blocked and retire_count holds 0. Combinational outputs follow their equations with the array at 0.
- Reset release: the first write commits on the first posedge where RST_N is high and wb_en=1.
- Reset asserted mid-operation clears all committed state. A write presented on the same edge as reset assertion is lost.
- Write latency: 1 cycle; regs reflects the write after the posedge. Bypass gives zero-latency visibility in the write cycle itself.
- The MEM/WB register updates its outputs on negedge CLK, so inputs are stable for the half cycle before the commit posedge. No extra input registering is allowed; it would add a cycle and break the forwarding assumption.
- Read outputs are purely combinational from read indices, array state and bypass inputs.
- Back-to-back writes to the same register on consecutive cycles: the last write wins, and each write counts.

## Test plan
- Reset: preload via writes, pulse RST_N low between edges -> all reads 0 and retire_count 0 immediately, with no posedge needed.
- Basic write/read: control_wb=2'b10, ALU_result=0x12345678, dst=5 -> after posedge, read_reg1=5 gives 0x12345678 and retire_count=1. Repeat with control_wb=2'b11, read_data=0xDEADBEEF, dst=6 -> reg6=0xDEADBEEF.
- Bypass: during a write of 0xCAFEF00D to reg 9, set read_reg1=read_reg2=9 before the edge -> both ports show 0xCAFEF00D in the same cycle.
- $0 protection: control_wb=2'b10, dst=0, ALU_result=0xFFFFFFFF -> read of 0 gives 0, wb_en_out=0, retire_count unchanged. Dst=0x00000020 (upper bits set, index 0) also gives no write.
- No-write: control_wb=2'b01, read_data=X, dst=7 -> reg7 unchanged, wb_en_out=0, no count.
- Counter wrap: force 0xFFFFFFFF committed writes (or a backdoor preload), then one write -> retire_count=0.
